// File: rtl/mux4_rr_sampler.sv
// mux4_rr_sampler: round-robin channel sampler for a downstream 4:1 mux.
// Grants one requesting channel, then collects DWELL consecutive samples
// of the mux output into out_data and holds the result until the consumer
// takes it with a valid/ready handshake.
module mux4_rr_sampler #(
  parameter int DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             mux_y,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [DWELL-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  // cnt must be able to reach DWELL itself without wrapping.
  localparam int CNT_W = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DWELL-1:0]   out_data_q, out_data_d;
  logic [1:0]         out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Requests rotated so that bit 0 is the channel at ptr; the first set
  // bit of req_rot is then the round-robin winner.
  logic [3:0]         req_rot;
  logic [1:0]         grant_off;
  logic [1:0]         grant_ch;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_q + 2'(gi)];
    end
  endgenerate

  // Priority pick on the rotated request vector, mapped back to a channel.
  always_comb begin
    grant_off = 2'd0;
    if (req_rot[0])      grant_off = 2'd0;
    else if (req_rot[1]) grant_off = 2'd1;
    else if (req_rot[2]) grant_off = 2'd2;
    else if (req_rot[3]) grant_off = 2'd3;
    grant_ch = ptr_q + grant_off;
  end

  // State register; all outputs come straight from these flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: grant in IDLE, shift samples in SHIFT, wait for the
  // handshake in HOLD. req is only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_d   = grant_ch;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // First sample taken ends up in the MSB.
        out_data_d = {out_data_q[DWELL-2:0], mux_y};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_ch_d    = sel_q;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          ptr_d       = sel_q + 2'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux4_rr_sampler.md
MUX4_RR_SAMPLER -- requirements
Module: mux4_rr_sampler

Interface
REQ-001 The block SHALL have parameter DWELL, default 8: the number of consecutive mux-output samples taken per granted channel, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: per-channel sample request, where req[i] requests channel i.
REQ-005 The block SHALL have port mux_y, input, 1 bit: the output of the downstream 4:1 mux, selected by sel.
REQ-006 The block SHALL have port sel, output, 2 bits: the select driven to the 4:1 mux.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-008 The block SHALL have port out_data, output, DWELL bits: the collected samples.
REQ-009 The block SHALL have port out_ch, output, 2 bits: the channel that out_data came from.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data and out_ch are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and HOLD, with all outputs registered.
REQ-013 In IDLE, if req is not zero, the block SHALL grant one channel by round-robin:
- the search starts at ptr, then ptr+1, ptr+2, ptr+3, all mod 4;
- on the grant edge: sel <= granted channel, cnt <= 0, state <= SHIFT.
REQ-014 In IDLE, if req is zero, the block SHALL leave sel and all other state unchanged.
REQ-015 In SHIFT, on each edge the block SHALL perform out_data <= {out_data[DWELL-2:0], mux_y}, so the first sample ends up in the MSB, and increment cnt.
REQ-016 On the edge that takes sample number DWELL, the block SHALL set state <= HOLD, out_valid <= 1 and out_ch <= sel.
REQ-017 Latency SHALL be as follows: if req is sampled on edge E, out_valid rises on edge E+DWELL and is visible in the cycle after that edge.
REQ-018 sel SHALL stay constant from the grant edge until the block next leaves IDLE; it changes only on a grant edge.
REQ-019 In HOLD, out_valid, out_data and out_ch SHALL stay stable until out_valid and out_ready are both high on an edge.
REQ-020 On that handshake edge the block SHALL set out_valid <= 0, ptr <= sel+1 (mod 4) and state <= IDLE.
REQ-021 The minimum spacing between grants SHALL be one IDLE cycle; back-to-back grants without an IDLE cycle SHALL NOT occur.
REQ-022 Changes to req during SHIFT or HOLD SHALL be ignored; the grant is not cancelled.
REQ-023 Channels SHALL be served fairly: with all four req bits held high, grants SHALL occur in the order 0,1,2,3,0,...
REQ-024 out_ready while out_valid is low SHALL have no effect.
REQ-025 The cnt width SHALL be sized to hold DWELL without overflow, and cnt SHALL NOT wrap within SHIFT.

Reset
REQ-026 While rst is high, the block SHALL hold the following values immediately, without waiting for a clock:
- state=IDLE, sel=0, ptr=0, cnt=0;
- out_data=0, out_ch=0, out_valid=0, busy=0.
REQ-027 Reset during SHIFT or HOLD SHALL discard the partial or pending sample, with no out_valid afterwards for that grant.
REQ-028 After rst deasserts, the first edge with req not zero SHALL grant per REQ-013 from ptr=0.

Verification
REQ-029 Single-channel case, DWELL=8: req=4'b0100, mux_y driving 1,0,1,1,0,0,1,0 on successive SHIFT edges, out_ready=1. Required response: sel=2 on the grant edge, out_valid high 8 edges later with out_data=8'hB2 and out_ch=2, and out_valid low one cycle later.
REQ-030 Round-robin: req=4'b1111 held, out_ready=1. Required response: out_ch sequence 0,1,2,3,0; busy drops for exactly one cycle between results.
REQ-031 Backpressure: out_ready=0 for 5 cycles while in HOLD, with mux_y toggling. Required response: out_valid, out_data and out_ch stay unchanged and sel stays unchanged; the result completes on the first edge with out_ready=1.
REQ-032 Skip idle channels: ptr=1 after serving channel 0, then req=4'b0001. Required response: channel 0 is granted again (search order 1,2,3,0).
REQ-033 Asynchronous reset mid-SHIFT: rst pulsed between clock edges after 3 samples. Required response: all outputs return to reset values before the next edge, and no out_valid follows.
REQ-034 Request drop: req goes to 0 one cycle after the grant. Required response: the grant still completes with out_valid after DWELL samples, then the block stays in IDLE.
